// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word fetches, queues responses in a 2-entry FIFO,
// and handles PC redirects by flushing and discarding stale in-flight responses.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [XLEN-1:0]        r_fetch_pc;
  logic [XLEN-1:0]        r_rsp_pc;
  logic [XLEN-1:0]        w_fetch_pc_nxt;
  logic [XLEN-1:0]        w_rsp_pc_nxt;
  logic [CNT_W-1:0]       r_outst;
  logic [CNT_W-1:0]       r_drop;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_outst_nxt;
  logic [CNT_W-1:0]       w_drop_nxt;
  logic [XLEN-1:0]        r_word [DEPTH];
  logic [XLEN-1:0]        r_pc   [DEPTH];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic                   w_fire;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;
  logic                   w_rsp_hit;
  logic                   w_drain_hit;
  logic [XLEN-1:0]        w_redir_pc;
  logic [CNT_W:0]         w_credit_used;

  // Credits cover both in-flight requests and queued words, so the FIFO never overflows
  assign w_credit_used  = {1'b0, r_outst} + {1'b0, r_count};
  assign imem_req_valid = (r_state == ST_FETCH) && (w_credit_used < 3'd2) && !redirect_valid;
  assign imem_addr      = r_fetch_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;
  assign w_redir_pc     = redirect_pc & ~32'h3;
  assign w_rsp_hit      = imem_rsp_valid && (r_outst != 2'd0);
  assign w_drain_hit    = imem_rsp_valid && (r_drop != 2'd0);

  assign inst_valid  = (r_count != 2'd0);
  assign instruction = r_word[r_rd_ptr];
  assign inst_pc     = r_pc[r_rd_ptr];
  assign w_pop       = inst_valid && inst_ready && !w_flush;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_rsp_pc_nxt   = r_rsp_pc;
    w_outst_nxt    = r_outst;
    w_drop_nxt     = r_drop;
    w_flush        = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (redirect_valid) begin
          // A response landing with the redirect is stale and counts against the drain
          w_flush        = 1'b1;
          w_fetch_pc_nxt = w_redir_pc;
          w_rsp_pc_nxt   = w_redir_pc;
          w_outst_nxt    = 2'd0;
          w_drop_nxt     = r_outst - 2'(w_rsp_hit);
          w_state_nxt    = (w_drop_nxt != 2'd0) ? ST_DRAIN : ST_FETCH;
        end else begin
          w_push      = w_rsp_hit;
          w_outst_nxt = r_outst + 2'(w_fire) - 2'(w_rsp_hit);
          if (w_fire)    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          if (w_rsp_hit) w_rsp_pc_nxt   = r_rsp_pc + 32'd4;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = w_redir_pc;
          w_rsp_pc_nxt   = w_redir_pc;
        end
        w_drop_nxt = r_drop - 2'(w_drain_hit);
        if (w_drop_nxt == 2'd0) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_outst    <= 2'd0;
      r_drop     <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_rsp_pc   <= w_rsp_pc_nxt;
      r_outst    <= w_outst_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  // Response FIFO of {word, pc}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_word[i] <= '0;
        r_pc[i]   <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (w_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_word[r_wr_ptr] <= imem_rdata;
        r_pc[r_wr_ptr]   <= r_rsp_pc;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table with a hand-driven
// memory, plus sequences for mid-stream reset and decoder backpressure.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, rv;
    logic [31:0] rd;
    logic        redir;
    logic [31:0] rpc;
    logic        irdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc, e_ins;
  } vec_t;

  localparam logic [31:0] B = 32'h1000_0000;
  localparam logic [31:0] D = 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic redir, input logic [31:0] rpc, input logic irdy,
                              input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_ipc, input logic [31:0] e_ins);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.redir = redir; v.rpc = rpc; v.irdy = irdy;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_ins = e_ins;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic redir, input logic [31:0] rpc, input logic irdy);
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rdata     = rd;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = irdy;
  endtask

  initial begin
    int   fires;
    logic pend;
    logic [31:0] pend_addr;

    // rdy, rv, rdata, redir, rpc, irdy | req_valid, addr, inst_valid, inst_pc, instruction
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  1, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 1, B,        0, 0, 1,  1, 32'h4,   0, 0, 0));
    vecs.push_back(mk(1, 1, B+32'h4,  0, 0, 1,  0, 32'h8,   1, 32'h0, B));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  1, 32'h8,   1, 32'h4, B+32'h4));
    vecs.push_back(mk(1, 1, B+32'h8,  0, 0, 1,  1, 32'hC,   0, 0, 0));
    vecs.push_back(mk(1, 1, B+32'hC,  0, 0, 1,  0, 32'h10,  1, 32'h8, B+32'h8));
    vecs.push_back(mk(1, 0, 0,        0, 0, 0,  1, 32'h10,  1, 32'hC, B+32'hC));
    vecs.push_back(mk(1, 1, B+32'h10, 0, 0, 0,  0, 32'h14,  1, 32'hC, B+32'hC));
    vecs.push_back(mk(1, 0, 0,        0, 0, 0,  0, 32'h14,  1, 32'hC, B+32'hC));
    vecs.push_back(mk(1, 0, 0,        0, 0, 0,  0, 32'h14,  1, 32'hC, B+32'hC));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  0, 32'h14,  1, 32'hC, B+32'hC));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 0,      0, 0, 0,  1, 32'h14,  1, 32'h10, B+32'h10));
    vecs.push_back(mk(1, 0, 0,        0, 0, 0,  1, 32'h14,  1, 32'h10, B+32'h10));
    vecs.push_back(mk(1, 0, 0,        1, 32'h203, 1, 0, 32'h18, 1, 32'h10, B+32'h10));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  0, 32'h200, 0, 0, 0));
    vecs.push_back(mk(1, 1, D,        0, 0, 1,  0, 32'h200, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  1, 32'h200, 0, 0, 0));
    vecs.push_back(mk(1, 1, B+32'h200, 0, 0, 1, 1, 32'h204, 0, 0, 0));
    vecs.push_back(mk(1, 1, D,        1, 32'h300, 1, 0, 32'h208, 1, 32'h200, B+32'h200));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  1, 32'h300, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  1, 32'h304, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  0, 32'h308, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,        1, 32'h100, 1, 0, 32'h308, 0, 0, 0));
    vecs.push_back(mk(1, 1, D,        0, 0, 1,  0, 32'h100, 0, 0, 0));
    vecs.push_back(mk(1, 1, D,        0, 0, 1,  0, 32'h100, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  1, 32'h100, 0, 0, 0));
    vecs.push_back(mk(1, 1, B+32'h100, 0, 0, 1, 1, 32'h104, 0, 0, 0));
    vecs.push_back(mk(1, 1, B+32'h104, 0, 0, 1, 0, 32'h108, 1, 32'h100, B+32'h100));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  1, 32'h108, 1, 32'h104, B+32'h104));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  1, 32'h108, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  1, 32'h10C, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,        1, 32'h500, 1, 0, 32'h110, 0, 0, 0));
    vecs.push_back(mk(1, 1, D,        1, 32'hFFFF_FFFF, 1, 0, 32'h500, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  0, 32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk(1, 1, D,        0, 0, 1,  0, 32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,        0, 0, 1,  1, 32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'hABCD_FFFC, 0, 0, 1, 1, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'hABCD_0000, 0, 0, 1, 0, 32'h4, 1, 32'hFFFF_FFFC, 32'hABCD_FFFC));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  1, 32'h4,   1, 32'h0, 32'hABCD_0000));
    vecs.push_back(mk(0, 1, D,        0, 0, 1,  1, 32'h4,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  1, 32'h4,   0, 0, 0));

    // Reset values
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("reset req_valid", 32'(imem_req_valid), 32'h0);
    check("reset addr", imem_addr, 32'h0);
    check("reset inst_valid", 32'(inst_valid), 32'h0);
    check("reset instruction", instruction, 32'h0);
    check("reset inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle req_valid", 32'(imem_req_valid), 32'h0);

    // Table: inputs applied after the falling edge, outputs checked before the rising edge
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].redir, vecs[i].rpc, vecs[i].irdy);
      #1;
      check($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rv));
      check($sformatf("row%0d addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        check($sformatf("row%0d inst_pc", i), inst_pc, vecs[i].e_ipc);
        check($sformatf("row%0d instruction", i), instruction, vecs[i].e_ins);
      end
    end

    // Reset asserted mid-stream with a request pending and an instruction queued
    @(negedge clk); drive(1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 1, B+32'h4, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    #1;
    check("pre-reset inst_valid", 32'(inst_valid), 32'h1);
    check("pre-reset req_valid", 32'(imem_req_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async reset inst_valid", 32'(inst_valid), 32'h0);
    check("async reset req_valid", 32'(imem_req_valid), 32'h0);
    check("async reset addr", imem_addr, 32'h0);
    check("async reset instruction", instruction, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset idle req_valid", 32'(imem_req_valid), 32'h0);

    // Decoder stalled for 10 cycles behind a 1-cycle memory: only two requests may issue
    fires = 0;
    pend = 1'b0;
    pend_addr = 32'h0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1, pend, 32'h7000_0000 | pend_addr, 0, 0, 0);
      #1;
      if (imem_req_valid && fires == 0)
        check("first refetch addr", imem_addr, 32'h0);
      pend_addr = imem_addr;
      pend = imem_req_valid;
      if (imem_req_valid) fires++;
    end
    check("stall request count", 32'(fires), 32'd2);
    check("stall head pc", inst_pc, 32'h0);
    check("stall head word", instruction, 32'h7000_0000);
    @(negedge clk); drive(1, 0, 0, 0, 0, 1);
    #1;
    check("full no request", 32'(imem_req_valid), 32'h0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0);
    #1;
    check("after pop req_valid", 32'(imem_req_valid), 32'h1);
    check("after pop addr", imem_addr, 32'h8);
    check("after pop inst_pc", inst_pc, 32'h4);
    check("after pop instruction", instruction, 32'h7000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
